// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer bundle: redirect/stall/halt controls in, fetch PC, flush and statistics out.
// Clock and reset stay outside the interface as plain ports of the sequencer.
interface pc_sequencer_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             stall;
  logic             bj_valid;
  logic             bj_is_jump;
  logic [PC_W-1:0]  bj_target;
  logic             halt_req;
  logic             resume;
  logic             cnt_clr;
  logic [PC_W-1:0]  pc;
  logic             fetch_valid;
  logic             flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] jump_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output stall, bj_valid, bj_is_jump, bj_target, halt_req, resume, cnt_clr,
    input  pc, fetch_valid, flush, state, branch_cnt, jump_cnt, stall_cnt
  );

  modport slave (
    input  stall, bj_valid, bj_is_jump, bj_target, halt_req, resume, cnt_clr,
    output pc, fetch_valid, flush, state, branch_cnt, jump_cnt, stall_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered fetch PC controller: one-cycle update of pc/flush/state, redirects held during stall.
// No backpressure of its own; stall/halt inputs freeze the PC and any redirect seen in a stall is buffered.
module pc_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t           state_q;
  logic [PC_W-1:0]  pc_q;
  logic             fetch_valid_q;
  logic             flush_q;
  logic             pend_valid_q;
  logic [PC_W-1:0]  pend_target_q;
  logic             pend_is_jump_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] jump_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic             load_en;
  logic [PC_W-1:0]  load_target;
  logic             load_is_jump;
  logic             capture_en;

  // Single point deciding which redirect (live or pending) lands in pc this edge.
  always_comb begin
    load_en      = 1'b0;
    load_target  = bus.bj_target;
    load_is_jump = bus.bj_is_jump;
    capture_en   = 1'b0;
    case (state_q)
      RUN: begin
        load_en    = !bus.halt_req && !bus.stall && bus.bj_valid;
        capture_en = !bus.halt_req && bus.stall && bus.bj_valid;
      end
      STALL: begin
        capture_en = !bus.halt_req && bus.stall && bus.bj_valid;
        if (!bus.halt_req && !bus.stall) begin
          if (bus.bj_valid) begin
            load_en = 1'b1;
          end else if (pend_valid_q) begin
            load_en      = 1'b1;
            load_target  = pend_target_q;
            load_is_jump = pend_is_jump_q;
          end
        end
      end
      HALT: begin
        if (!bus.halt_req && bus.resume && pend_valid_q) begin
          load_en      = 1'b1;
          load_target  = pend_target_q;
          load_is_jump = pend_is_jump_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      fetch_valid_q  <= 1'b0;
      flush_q        <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_target_q  <= '0;
      pend_is_jump_q <= 1'b0;
    end else begin
      // Loads only happen on a transition into RUN, so flush never shows in BOOT/HALT.
      flush_q <= load_en;
      if (capture_en) begin
        pend_valid_q   <= 1'b1;
        pend_target_q  <= bus.bj_target;
        pend_is_jump_q <= bus.bj_is_jump;
      end
      if (load_en) begin
        pc_q         <= load_target;
        pend_valid_q <= 1'b0;
      end
      case (state_q)
        BOOT: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN: begin
          if (bus.halt_req) begin
            state_q       <= HALT;
            fetch_valid_q <= 1'b0;
          end else if (bus.stall) begin
            state_q       <= STALL;
            fetch_valid_q <= 1'b0;
          end else if (!load_en) begin
            pc_q <= pc_q + 1'b1;
          end
        end
        STALL: begin
          if (bus.halt_req) begin
            state_q <= HALT;
          end else if (!bus.stall) begin
            state_q       <= RUN;
            fetch_valid_q <= 1'b1;
            if (!load_en) pc_q <= pc_q + 1'b1;
          end
        end
        HALT: begin
          // Without a pending redirect the resume edge holds pc; stepping starts next edge.
          if (!bus.halt_req && bus.resume) begin
            state_q       <= RUN;
            fetch_valid_q <= 1'b1;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= '0;
      jump_cnt_q   <= '0;
      stall_cnt_q  <= '0;
    end else if (bus.cnt_clr) begin
      branch_cnt_q <= '0;
      jump_cnt_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (load_en && !load_is_jump && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
      if (load_en && load_is_jump && jump_cnt_q != '1)    jump_cnt_q   <= jump_cnt_q + 1'b1;
      if (state_q == STALL && stall_cnt_q != '1)          stall_cnt_q  <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush       = flush_q;
  assign bus.state       = state_q;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.jump_cnt    = jump_cnt_q;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: 16-bit PC starting at 0x100, 8-bit counters so saturation is reachable.
module tb_pc_sequencer;
  localparam int PC_W  = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) sif ();

  pc_sequencer #(
    .PC_W    (PC_W),
    .RESET_PC(16'h0100),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sif.stall      = 1'b0;
    sif.bj_valid   = 1'b0;
    sif.bj_is_jump = 1'b0;
    sif.bj_target  = '0;
    sif.halt_req   = 1'b0;
    sif.resume     = 1'b0;
    sif.cnt_clr    = 1'b0;
  endtask

  // Jump to a known pc while clearing counters; the clear wins so no jump is counted.
  task automatic set_pc(input logic [PC_W-1:0] target);
    sif.bj_valid   = 1'b1;
    sif.bj_is_jump = 1'b1;
    sif.bj_target  = target;
    sif.cnt_clr    = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    checks++; if (sif.pc !== 16'h0100) begin errors++; $display("FAIL reset_pc got %h exp 0100", sif.pc); end
    checks++; if (sif.state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", sif.state); end
    checks++; if (sif.fetch_valid !== 1'b0 || sif.flush !== 1'b0) begin errors++; $display("FAIL reset_fv_flush got %b%b exp 00", sif.fetch_valid, sif.flush); end
    checks++; if (sif.branch_cnt !== 8'd0 || sif.jump_cnt !== 8'd0 || sif.stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d/%0d exp 0/0/0", sif.branch_cnt, sif.jump_cnt, sif.stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (sif.state !== 2'd0 || sif.fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_state got %0d fv %b exp 0 fv 0", sif.state, sif.fetch_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (sif.pc !== 16'h0100 + 16'(i) || sif.fetch_valid !== 1'b1 || sif.flush !== 1'b0 || sif.state !== 2'd1)
        begin errors++; $display("FAIL seq_step%0d got pc %h fv %b fl %b st %0d exp pc %h fv 1 fl 0 st 1", i, sif.pc, sif.fetch_valid, sif.flush, sif.state, 16'h0100 + 16'(i)); end
    end
  endtask

  task automatic test_redirect();
    set_pc(16'h0010);
    checks++; if (sif.pc !== 16'h0010 || sif.jump_cnt !== 8'd0) begin errors++; $display("FAIL clr_beats_jump got pc %h jc %0d exp 0010 0", sif.pc, sif.jump_cnt); end
    sif.bj_valid = 1'b1; sif.bj_is_jump = 1'b0; sif.bj_target = 16'h0040;
    tick();
    clear_inputs();
    checks++; if (sif.pc !== 16'h0040 || sif.flush !== 1'b1) begin errors++; $display("FAIL branch_load got pc %h fl %b exp 0040 1", sif.pc, sif.flush); end
    checks++; if (sif.branch_cnt !== 8'd1 || sif.jump_cnt !== 8'd0) begin errors++; $display("FAIL branch_cnt got %0d/%0d exp 1/0", sif.branch_cnt, sif.jump_cnt); end
    tick();
    checks++; if (sif.pc !== 16'h0041 || sif.flush !== 1'b0) begin errors++; $display("FAIL post_branch got pc %h fl %b exp 0041 0", sif.pc, sif.flush); end
  endtask

  task automatic test_stall_pending();
    set_pc(16'h0042);
    sif.stall = 1'b1; sif.bj_valid = 1'b1; sif.bj_is_jump = 1'b1; sif.bj_target = 16'h0080;
    tick();
    checks++; if (sif.state !== 2'd2 || sif.pc !== 16'h0042 || sif.fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_enter got st %0d pc %h fv %b exp 2 0042 0", sif.state, sif.pc, sif.fetch_valid); end
    sif.bj_is_jump = 1'b0; sif.bj_target = 16'h0090;
    tick();
    sif.bj_valid = 1'b0;
    tick();
    checks++; if (sif.pc !== 16'h0042 || sif.flush !== 1'b0 || sif.stall_cnt !== 8'd2) begin errors++; $display("FAIL stall_hold got pc %h fl %b sc %0d exp 0042 0 2", sif.pc, sif.flush, sif.stall_cnt); end
    sif.stall = 1'b0;
    tick();
    checks++; if (sif.pc !== 16'h0090 || sif.flush !== 1'b1 || sif.state !== 2'd1) begin errors++; $display("FAIL stall_release got pc %h fl %b st %0d exp 0090 1 1", sif.pc, sif.flush, sif.state); end
    checks++; if (sif.stall_cnt !== 8'd3 || sif.branch_cnt !== 8'd1 || sif.jump_cnt !== 8'd0) begin errors++; $display("FAIL stall_cnts got sc %0d bc %0d jc %0d exp 3 1 0", sif.stall_cnt, sif.branch_cnt, sif.jump_cnt); end
    tick();
    checks++; if (sif.pc !== 16'h0091 || sif.flush !== 1'b0) begin errors++; $display("FAIL stall_after got pc %h fl %b exp 0091 0", sif.pc, sif.flush); end
  endtask

  task automatic test_stall_precedence();
    set_pc(16'h00A0);
    sif.stall = 1'b1; sif.bj_valid = 1'b1; sif.bj_is_jump = 1'b1; sif.bj_target = 16'h00AA;
    tick();
    sif.stall = 1'b0; sif.bj_is_jump = 1'b0; sif.bj_target = 16'h00B0;
    tick();
    clear_inputs();
    checks++; if (sif.pc !== 16'h00B0 || sif.flush !== 1'b1 || sif.branch_cnt !== 8'd1 || sif.jump_cnt !== 8'd0)
      begin errors++; $display("FAIL live_beats_pend got pc %h fl %b bc %0d jc %0d exp 00b0 1 1 0", sif.pc, sif.flush, sif.branch_cnt, sif.jump_cnt); end
    tick();
    checks++; if (sif.pc !== 16'h00B1) begin errors++; $display("FAIL pend_dropped got pc %h exp 00b1", sif.pc); end
  endtask

  task automatic test_halt();
    set_pc(16'h0030);
    sif.halt_req = 1'b1; sif.bj_valid = 1'b1; sif.bj_is_jump = 1'b0; sif.bj_target = 16'h0055;
    tick();
    clear_inputs();
    checks++; if (sif.state !== 2'd3 || sif.pc !== 16'h0030 || sif.fetch_valid !== 1'b0 || sif.flush !== 1'b0)
      begin errors++; $display("FAIL halt_enter got st %0d pc %h fv %b fl %b exp 3 0030 0 0", sif.state, sif.pc, sif.fetch_valid, sif.flush); end
    for (int i = 0; i < 5; i++) begin
      sif.bj_valid = 1'b1; sif.stall = (i == 2);
      tick();
      checks++; if (sif.state !== 2'd3 || sif.pc !== 16'h0030 || sif.flush !== 1'b0) begin errors++; $display("FAIL halt_hold%0d got st %0d pc %h fl %b exp 3 0030 0", i, sif.state, sif.pc, sif.flush); end
    end
    clear_inputs();
    sif.halt_req = 1'b1; sif.resume = 1'b1;
    tick();
    checks++; if (sif.state !== 2'd3) begin errors++; $display("FAIL halt_wins got st %0d exp 3", sif.state); end
    sif.halt_req = 1'b0;
    tick();
    clear_inputs();
    checks++; if (sif.state !== 2'd1 || sif.pc !== 16'h0030 || sif.fetch_valid !== 1'b1 || sif.flush !== 1'b0)
      begin errors++; $display("FAIL resume got st %0d pc %h fv %b fl %b exp 1 0030 1 0", sif.state, sif.pc, sif.fetch_valid, sif.flush); end
    tick();
    checks++; if (sif.pc !== 16'h0031 || sif.branch_cnt !== 8'd0 || sif.jump_cnt !== 8'd0 || sif.stall_cnt !== 8'd0)
      begin errors++; $display("FAIL resume_step got pc %h cnts %0d/%0d/%0d exp 0031 0/0/0", sif.pc, sif.branch_cnt, sif.jump_cnt, sif.stall_cnt); end
  endtask

  task automatic test_halt_pending();
    set_pc(16'h0060);
    sif.stall = 1'b1; sif.bj_valid = 1'b1; sif.bj_is_jump = 1'b1; sif.bj_target = 16'h00C0;
    tick();
    sif.bj_valid = 1'b0; sif.halt_req = 1'b1;
    tick();
    clear_inputs();
    tick();
    checks++; if (sif.state !== 2'd3 || sif.pc !== 16'h0060 || sif.jump_cnt !== 8'd0) begin errors++; $display("FAIL stall_to_halt got st %0d pc %h jc %0d exp 3 0060 0", sif.state, sif.pc, sif.jump_cnt); end
    sif.resume = 1'b1;
    tick();
    clear_inputs();
    checks++; if (sif.pc !== 16'h00C0 || sif.flush !== 1'b1 || sif.jump_cnt !== 8'd1 || sif.state !== 2'd1)
      begin errors++; $display("FAIL resume_pend got pc %h fl %b jc %0d st %0d exp 00c0 1 1 1", sif.pc, sif.flush, sif.jump_cnt, sif.state); end
  endtask

  task automatic test_wrap();
    set_pc(16'hFFFF);
    tick();
    checks++; if (sif.pc !== 16'h0000 || sif.flush !== 1'b0) begin errors++; $display("FAIL pc_wrap got pc %h fl %b exp 0000 0", sif.pc, sif.flush); end
  endtask

  task automatic test_saturate();
    set_pc(16'h0020);
    sif.bj_valid = 1'b1; sif.bj_is_jump = 1'b0; sif.bj_target = 16'h0020;
    for (int i = 0; i < 255; i++) tick();
    checks++; if (sif.branch_cnt !== 8'hFF) begin errors++; $display("FAIL sat_reach got %0d exp 255", sif.branch_cnt); end
    tick();
    checks++; if (sif.branch_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold got %0d exp 255", sif.branch_cnt); end
    sif.cnt_clr = 1'b1;
    tick();
    clear_inputs();
    checks++; if (sif.branch_cnt !== 8'd0) begin errors++; $display("FAIL clr_priority got %0d exp 0", sif.branch_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    set_pc(16'h0070);
    sif.stall = 1'b1; sif.bj_valid = 1'b1; sif.bj_is_jump = 1'b1; sif.bj_target = 16'h0077;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sif.pc !== 16'h0100 || sif.state !== 2'd0 || sif.fetch_valid !== 1'b0)
      begin errors++; $display("FAIL async_reset got pc %h st %0d fv %b exp 0100 0 0", sif.pc, sif.state, sif.fetch_valid); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (sif.pc !== 16'h0100 || sif.flush !== 1'b0 || sif.state !== 2'd1) begin errors++; $display("FAIL rst_release got pc %h fl %b st %0d exp 0100 0 1", sif.pc, sif.flush, sif.state); end
    tick();
    checks++; if (sif.pc !== 16'h0101 || sif.flush !== 1'b0 || sif.jump_cnt !== 8'd0) begin errors++; $display("FAIL no_pend_after_rst got pc %h fl %b jc %0d exp 0101 0 0", sif.pc, sif.flush, sif.jump_cnt); end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_stall_pending();
    test_stall_precedence();
    test_halt();
    test_halt_pending();
    test_wrap();
    test_saturate();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
